// File: rtl/topk_collector.sv
// Heavy-hitter table fed by the merging query queue: accumulates (item, count) records and dumps/clears on request.
// Optional macro TOPK_REPLACE_EN enables minimum-count replacement when the table is full.
module topk_collector #(
    parameter int ITEM_LENGTH        = 48,
    parameter int ITEM_COUNTER_SIZE  = 12,
    parameter int TOTAL_COUNTER_SIZE = 16,
    parameter int TABLE_SIZE         = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          valid_in,
    input  logic [ITEM_LENGTH-1:0]        item_in,
    input  logic [ITEM_COUNTER_SIZE-1:0]  item_counter_in,
    output logic                          ready_out,
    input  logic                          dump_req,
    output logic                          dump_valid,
    output logic [ITEM_LENGTH-1:0]        dump_item,
    output logic [TOTAL_COUNTER_SIZE-1:0] dump_count,
    input  logic                          dump_ready,
    output logic                          dump_done,
    output logic [7:0]                    occupancy,
    output logic [15:0]                   drop_cnt
);
    localparam int IDX_W = $clog2(TABLE_SIZE);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_LOOKUP, S_UPDATE, S_DUMP} state_t;

    function automatic logic [TOTAL_COUNTER_SIZE-1:0] sat_add(
        input logic [TOTAL_COUNTER_SIZE-1:0] a,
        input logic [ITEM_COUNTER_SIZE-1:0]  b
    );
        logic [TOTAL_COUNTER_SIZE:0] s;
        s = {1'b0, a} + (TOTAL_COUNTER_SIZE+1)'(b);
        return s[TOTAL_COUNTER_SIZE] ? '1 : s[TOTAL_COUNTER_SIZE-1:0];
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] a);
        return (a == 16'hFFFF) ? a : a + 16'd1;
    endfunction

    state_t                        state_q, state_d;
    logic [TABLE_SIZE-1:0]         vld_q, vld_d;
    logic [ITEM_LENGTH-1:0]        item_tab_q [TABLE_SIZE];
    logic [ITEM_LENGTH-1:0]        item_tab_d [TABLE_SIZE];
    logic [TOTAL_COUNTER_SIZE-1:0] cnt_tab_q  [TABLE_SIZE];
    logic [TOTAL_COUNTER_SIZE-1:0] cnt_tab_d  [TABLE_SIZE];
    logic [ITEM_LENGTH-1:0]        rec_item_q, rec_item_d;
    logic [ITEM_COUNTER_SIZE-1:0]  rec_cnt_q, rec_cnt_d;
    logic                          hit_q, hit_d, free_q, free_d;
    logic [IDX_W-1:0]              hit_idx_q, hit_idx_d, free_idx_q, free_idx_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [7:0]                    occ_q, occ_d;
    logic [15:0]                   drop_q, drop_d;
    logic                          dump_done_q, dump_done_d;

    logic                          lk_hit, lk_free;
    logic [IDX_W-1:0]              lk_hit_idx, lk_free_idx;

    // Parallel match and free-slot search; descending walk leaves the lowest index.
    always_comb begin
        lk_hit      = 1'b0;
        lk_hit_idx  = '0;
        lk_free     = 1'b0;
        lk_free_idx = '0;
        for (int i = TABLE_SIZE-1; i >= 0; i--) begin
            if (vld_q[i] && item_tab_q[i] == rec_item_q) begin
                lk_hit     = 1'b1;
                lk_hit_idx = IDX_W'(i);
            end
            if (!vld_q[i]) begin
                lk_free     = 1'b1;
                lk_free_idx = IDX_W'(i);
            end
        end
    end

`ifdef TOPK_REPLACE_EN
    logic [IDX_W-1:0]              min_idx_q, min_idx_d, lk_min_idx;
    logic [TOTAL_COUNTER_SIZE-1:0] lk_min_cnt;

    // Only consulted when the table is full, so every entry is valid here.
    always_comb begin
        lk_min_idx = '0;
        lk_min_cnt = cnt_tab_q[0];
        for (int i = 1; i < TABLE_SIZE; i++) begin
            if (cnt_tab_q[i] < lk_min_cnt) begin
                lk_min_cnt = cnt_tab_q[i];
                lk_min_idx = IDX_W'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        vld_d       = vld_q;
        item_tab_d  = item_tab_q;
        cnt_tab_d   = cnt_tab_q;
        rec_item_d  = rec_item_q;
        rec_cnt_d   = rec_cnt_q;
        hit_d       = hit_q;
        hit_idx_d   = hit_idx_q;
        free_d      = free_q;
        free_idx_d  = free_idx_q;
        idx_d       = idx_q;
        occ_d       = occ_q;
        drop_d      = drop_q;
        dump_done_d = 1'b0;
`ifdef TOPK_REPLACE_EN
        min_idx_d   = min_idx_q;
`endif
        case (state_q)
            S_INIT: state_d = S_IDLE;
            S_IDLE: begin
                if (dump_req) begin
                    state_d = S_DUMP;
                    idx_d   = '0;
                end else if (valid_in) begin
                    rec_item_d = item_in;
                    rec_cnt_d  = item_counter_in;
                    state_d    = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                hit_d      = lk_hit;
                hit_idx_d  = lk_hit_idx;
                free_d     = lk_free;
                free_idx_d = lk_free_idx;
`ifdef TOPK_REPLACE_EN
                min_idx_d  = lk_min_idx;
`endif
                state_d    = S_UPDATE;
            end
            S_UPDATE: begin
                if (hit_q) begin
                    cnt_tab_d[hit_idx_q] = sat_add(cnt_tab_q[hit_idx_q], rec_cnt_q);
                end else if (free_q) begin
                    vld_d[free_idx_q]      = 1'b1;
                    item_tab_d[free_idx_q] = rec_item_q;
                    cnt_tab_d[free_idx_q]  = TOTAL_COUNTER_SIZE'(rec_cnt_q);
                    occ_d                  = occ_q + 8'd1;
                end else begin
`ifdef TOPK_REPLACE_EN
                    if (TOTAL_COUNTER_SIZE'(rec_cnt_q) > cnt_tab_q[min_idx_q]) begin
                        item_tab_d[min_idx_q] = rec_item_q;
                        cnt_tab_d[min_idx_q]  = TOTAL_COUNTER_SIZE'(rec_cnt_q);
                    end else begin
                        drop_d = sat_inc16(drop_q);
                    end
`else
                    drop_d = sat_inc16(drop_q);
`endif
                end
                state_d = S_IDLE;
            end
            S_DUMP: begin
                // Invalid entries advance unconditionally; valid ones wait for the consumer.
                if (!vld_q[idx_q] || dump_ready) begin
                    if (idx_q == IDX_W'(TABLE_SIZE-1)) begin
                        vld_d       = '0;
                        occ_d       = 8'd0;
                        dump_done_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            vld_q       <= '0;
            idx_q       <= '0;
            occ_q       <= 8'd0;
            drop_q      <= 16'd0;
            dump_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vld_q       <= vld_d;
            idx_q       <= idx_d;
            occ_q       <= occ_d;
            drop_q      <= drop_d;
            dump_done_q <= dump_done_d;
        end
    end

    // Payload storage is qualified by vld_q and the FSM, so it carries no reset.
    always_ff @(posedge clk) begin
        item_tab_q <= item_tab_d;
        cnt_tab_q  <= cnt_tab_d;
        rec_item_q <= rec_item_d;
        rec_cnt_q  <= rec_cnt_d;
        hit_q      <= hit_d;
        hit_idx_q  <= hit_idx_d;
        free_q     <= free_d;
        free_idx_q <= free_idx_d;
`ifdef TOPK_REPLACE_EN
        min_idx_q  <= min_idx_d;
`endif
    end

    assign ready_out  = (state_q == S_IDLE) && !dump_req;
    assign dump_valid = (state_q == S_DUMP) && vld_q[idx_q];
    assign dump_item  = dump_valid ? item_tab_q[idx_q] : '0;
    assign dump_count = dump_valid ? cnt_tab_q[idx_q] : '0;
    assign dump_done  = dump_done_q;
    assign occupancy  = occ_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_topk_collector.sv
// Directed bench for topk_collector: reference table model plus a dump scoreboard queue.
module tb_topk_collector;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic [47:0] item_in = '0;
    logic [11:0] item_counter_in = '0;
    logic        ready_out;
    logic        dump_req = 1'b0;
    logic        dump_valid;
    logic [47:0] dump_item;
    logic [15:0] dump_count;
    logic        dump_ready = 1'b0;
    logic        dump_done;
    logic [7:0]  occupancy;
    logic [15:0] drop_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    bit          m_vld  [8];
    logic [47:0] m_item [8];
    logic [15:0] m_cnt  [8];
    logic [7:0]  m_occ  = 8'd0;
    logic [15:0] m_drop = 16'd0;
    logic [63:0] exp_q [$];

    topk_collector dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .item_in(item_in),
        .item_counter_in(item_counter_in), .ready_out(ready_out), .dump_req(dump_req),
        .dump_valid(dump_valid), .dump_item(dump_item), .dump_count(dump_count),
        .dump_ready(dump_ready), .dump_done(dump_done), .occupancy(occupancy),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_vld[i] = 1'b0;
        m_occ  = 8'd0;
        m_drop = 16'd0;
    endtask

    task automatic model_rec(input logic [47:0] it, input logic [11:0] c);
        int hit, fr;
        logic [16:0] s;
        hit = -1; fr = -1;
        for (int i = 7; i >= 0; i--) begin
            if (m_vld[i] && m_item[i] == it) hit = i;
            if (!m_vld[i]) fr = i;
        end
        if (hit >= 0) begin
            s = {1'b0, m_cnt[hit]} + {5'd0, c};
            m_cnt[hit] = s[16] ? 16'hFFFF : s[15:0];
        end else if (fr >= 0) begin
            m_vld[fr] = 1'b1; m_item[fr] = it; m_cnt[fr] = {4'd0, c};
            m_occ++;
        end else begin
`ifdef TOPK_REPLACE_EN
            int mn;
            mn = 0;
            for (int i = 1; i < 8; i++) if (m_cnt[i] < m_cnt[mn]) mn = i;
            if ({4'd0, c} > m_cnt[mn]) begin
                m_item[mn] = it; m_cnt[mn] = {4'd0, c};
            end else if (m_drop != 16'hFFFF) m_drop++;
`else
            if (m_drop != 16'hFFFF) m_drop++;
`endif
        end
    endtask

    // Called at a negedge; returns at the negedge after the record has been applied.
    task automatic send(input logic [47:0] it, input logic [11:0] c);
        int t;
        item_in = it; item_counter_in = c; valid_in = 1'b1; t = 0;
        while (!ready_out && t < 20) begin @(negedge clk); t++; end
        check("send_ready", ready_out, 1);
        @(negedge clk);
        valid_in = 1'b0;
        check("busy_lookup", ready_out, 0);
        model_rec(it, c);
        @(negedge clk);
        @(negedge clk);
        check("ready_back", ready_out, 1);
        check("occupancy", occupancy, m_occ);
        check("drop_cnt", drop_cnt, m_drop);
    endtask

    task automatic push_expected();
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            if (m_vld[i]) exp_q.push_back({m_cnt[i], m_item[i]});
            m_vld[i] = 1'b0;
        end
        m_occ = 8'd0;
    endtask

    task automatic do_dump(input bit toggle, input bit hold_valid, output int cycles);
        logic [47:0] h_item;
        logic [15:0] h_cnt;
        logic [63:0] e;
        bit held;
        int ndone;
        push_expected();
        if (hold_valid) begin
            valid_in = 1'b1; item_in = 48'h77; item_counter_in = 12'd1;
        end
        dump_req = 1'b1;
        #1 check("dump_ready_drop", ready_out, 0);
        @(negedge clk);
        dump_req = 1'b0; held = 1'b0; ndone = 0; cycles = 0;
        while (cycles < 200) begin
            dump_ready = toggle ? cycles[0] : 1'b1;
            #1;
            if (dump_done) begin ndone++; break; end
            if (hold_valid) check("ready_in_dump", ready_out, 0);
            if (held) begin
                check("hold_valid", dump_valid, 1);
                check("hold_item", dump_item, h_item);
                check("hold_count", dump_count, h_cnt);
            end
            held = 1'b0;
            if (dump_valid) begin
                if (dump_ready) begin
                    check("dump_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("dump_item", dump_item, e[47:0]);
                        check("dump_count", dump_count, e[63:48]);
                    end
                end else begin
                    held = 1'b1; h_item = dump_item; h_cnt = dump_count;
                end
            end
            @(negedge clk);
            cycles++;
        end
        valid_in = 1'b0; dump_ready = 1'b0;
        check("dump_done_once", ndone, 1);
        check("dump_all_seen", exp_q.size(), 0);
        check("occ_after_dump", occupancy, 0);
        @(negedge clk);
        #1 check("dump_done_pulse", dump_done, 0);
        check("occ_no_insert", occupancy, 0);
    endtask

    initial begin
        int cyc, pops, t;
        logic [63:0] e;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_ready", ready_out, 0);
        check("rst_dump_valid", dump_valid, 0);
        check("rst_dump_done", dump_done, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_dump_item", dump_item, 0);
        check("rst_dump_count", dump_count, 0);
        rst_n = 1'b1;
        #1 check("init_ready", ready_out, 0);
        @(negedge clk);
        check("idle_ready", ready_out, 1);

        // Merge of one key
        send(48'd5, 12'd3);
        send(48'd5, 12'd4);
        do_dump(1'b0, 1'b0, cyc);

        // Saturation, then further add to a saturated entry
        for (int i = 0; i < 17; i++) send(48'd9, 12'd4095);
        do_dump(1'b0, 1'b0, cyc);
        for (int i = 0; i < 17; i++) send(48'd9, 12'd4095);
        send(48'd9, 12'd1);
        do_dump(1'b0, 1'b0, cyc);

        // Full table: replacement or drop
        for (int i = 1; i <= 8; i++) send(48'(i), 12'(9 + i));
        send(48'd100, 12'd11);
        send(48'd101, 12'd5);
        do_dump(1'b0, 1'b0, cyc);

        // Zero counts plus back-pressured dump with valid_in held high
        send(48'd20, 12'd1);
        send(48'd21, 12'd0);
        send(48'd22, 12'd3);
        send(48'd21, 12'd0);
        do_dump(1'b1, 1'b1, cyc);

        // Empty dump walks every index once
        do_dump(1'b0, 1'b0, cyc);
        check("empty_dump_cycles", cyc, 8);

        // Reset in the middle of a dump
        for (int i = 0; i < 4; i++) send(48'(30 + i), 12'd1);
        push_expected();
        dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0; dump_ready = 1'b1; pops = 0; t = 0;
        while (pops < 2 && t < 50) begin
            #1;
            if (dump_valid) begin
                e = exp_q.pop_front();
                check("mid_item", dump_item, e[47:0]);
                pops++;
            end
            @(negedge clk);
            t++;
        end
        check("mid_pops", pops, 2);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("mid_rst_valid", dump_valid, 0);
        check("mid_rst_done", dump_done, 0);
        check("mid_rst_occ", occupancy, 0);
        check("mid_rst_ready", ready_out, 0);
        dump_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_no_done", dump_done, 0);
        end
        check("post_rst_occ", occupancy, 0);
        check("post_rst_ready", ready_out, 1);
        check("post_rst_drop", drop_cnt, m_drop);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/topk_collector.md
# topk_collector

Downstream consumer of the merging query queue: pops merged (item, count) records through a valid/ready handshake and accumulates them into a small fully associative heavy-hitter table of `TABLE_SIZE` entries. On miss with a full table it evicts the minimum-count entry. On request it streams the table contents out and clears it. It drives the queue's `output_ready` and is the last stage before the host-side report path.

## Interface
- `ITEM_LENGTH`, 48, item key width
- `ITEM_COUNTER_SIZE`, 12, incoming merged-count width
- `TOTAL_COUNTER_SIZE`, 16, per-entry accumulated count width (must be ≥ `ITEM_COUNTER_SIZE`)
- `TABLE_SIZE`, 8, number of entries (2..255)

Ports:
- `clk` in 1: single clock, all state on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `valid_in` in 1: upstream record valid
- `item_in` in `ITEM_LENGTH`: record key
- `item_counter_in` in `ITEM_COUNTER_SIZE`: record count
- `ready_out` out 1: accept; record taken on `valid_in && ready_out`
- `dump_req` in 1: request table dump (level, sampled in IDLE)
- `dump_valid` out 1: dump record valid
- `dump_item` out `ITEM_LENGTH`: dump key
- `dump_count` out `TOTAL_COUNTER_SIZE`: dump count
- `dump_ready` in 1: dump consumer ready
- `dump_done` out 1: one-cycle pulse after final dump step
- `occupancy` out 8: number of valid entries
- `drop_cnt` out 16: saturating count of records not stored

## Operation
- Table entry = {vld, item, count}. FSM states: S_INIT, S_IDLE, S_LOOKUP, S_UPDATE, S_DUMP.
- S_INIT: entered on reset. Moves to S_IDLE on the first clock after `rst_n` is released.
- S_IDLE: `ready_out = !dump_req`.
  - If `dump_req`, go to S_DUMP with index 0.
  - Otherwise, on handshake, latch the record and go to S_LOOKUP.
- S_LOOKUP:
  - Compare the latched item against all valid entries in parallel.
  - Register hit and hit index, lowest free index, and min index. The min index is the lowest index among entries with the minimum count.
  - Go to S_UPDATE.
- S_UPDATE applies exactly one action, then goes to S_IDLE:
  - Hit: count = min(count + counter_in, 2^TOTAL_COUNTER_SIZE−1).
  - Miss with a free slot: write {1, item, zero-extended counter_in} at the lowest free index; `occupancy` +1.
  - Miss with a full table: replacement policy per Configuration. A record that is not stored increments `drop_cnt`, which saturates at 0xFFFF.
- S_DUMP: walks index 0..TABLE_SIZE−1.
  - Valid entry: `dump_valid = 1` with the entry's item and count, held stable until `dump_ready`; advance on `dump_valid && dump_ready`.
  - Invalid entry: skipped in one cycle with `dump_valid = 0`.
  - After the last index: clear all vld bits, set `occupancy = 0`, pulse `dump_done`, go to S_IDLE.
  - `drop_cnt` is not cleared by a dump.
- Throughput: one record per 3 cycles. `ready_out` is 0 in every state except S_IDLE.
- Zero-count records (`item_counter_in = 0`) are processed normally.
  - A hit is a no-op add.
  - A miss with a free slot inserts count 0.

## Timing
- Reset values (asynchronous, immediate): state S_INIT, all vld = 0.
  - Outputs: `ready_out` 0, `dump_valid` 0, `dump_done` 0, `occupancy` 0, `drop_cnt` 0, `dump_item` 0, `dump_count` 0.
- After the accept edge, the table and `occupancy` reflect the record 2 edges later (end of S_UPDATE). `ready_out` returns high in the following cycle.
- `dump_req` raised in S_IDLE: `ready_out` drops combinationally in the same cycle, so no record is lost or duplicated. The first `dump_valid` appears on the next cycle if entry 0 is valid.
- `dump_req` raised while a record is in flight: honoured on return to S_IDLE, after the update completes.
- `valid_in` held high during S_DUMP or S_LOOKUP/S_UPDATE has no effect.
- Dump latency:
  - Empty table: TABLE_SIZE cycles plus 1 cycle for the `dump_done` pulse.
  - Each valid entry: at least 1 cycle, extended while `dump_ready` is low.
- `rst_n` low mid-dump or mid-update: the table clears immediately and the partial dump is abandoned without `dump_done`.

## Configuration
- `TOPK_REPLACE_EN` defined: on a miss with a full table, if the zero-extended counter_in is strictly greater than the min entry's count, overwrite the min entry with {item, counter_in}. Otherwise drop the record and increment `drop_cnt`.
- `TOPK_REPLACE_EN` undefined: every miss with a full table is dropped and `drop_cnt` is incremented. The min-search logic is not built.

## Test plan
- Reset release: `ready_out` 0 on the first edge, 1 from the second; `occupancy` 0; `dump_valid` 0; `drop_cnt` 0.
- Merge: send (5, 3) then (5, 4), then dump → one record 5:7; `dump_done` pulses once; afterwards `occupancy` 0.
- Saturation: send item 9 with count 4095 seventeen times → dump shows 9:65535; a further (9, 1) still leaves 65535.
- Eviction: fill items 1..8 with counts 10..17, then send (100, 11) and (101, 5).
  - With `TOPK_REPLACE_EN`: dump lists 100:11 at index 0; `drop_cnt` 1.
  - Without `TOPK_REPLACE_EN`: items 1..8 unchanged; `drop_cnt` 2.
- Dump back-pressure: 3 entries stored in indices 0, 1, 2; `dump_ready` toggles every cycle.
  - Records arrive in index order, stable while `dump_ready` is low.
  - `valid_in` held at 1 throughout → `ready_out` stays 0 and no insert occurs.
- Reset mid-dump: assert `rst_n` low after 2 of 4 records → `dump_valid` 0 immediately, no `dump_done`, `occupancy` 0 after release.
